// File: rtl/sat_accumulator.sv
// sat_accumulator
//
// Sums frames of LEN input samples into an ACC_WIDTH-bit accumulator. Every
// beat saturates on its own: a clamped value is not sticky, so later beats
// keep adding to it. A sticky flag records whether any beat of the current
// frame clamped. After the LEN-th accepted beat the block holds the result
// until the consumer takes it, then starts the next frame from zero.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both 1. The producer keeps data stable while
// valid=1 and ready=0. in_ready and out_valid depend only on the FSM state,
// the clear input and rst_n, and never on the partner's valid/ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous frame abort; discards any partial or pending result
//   in_valid   in_data holds a sample
//   in_ready   block accepts a sample this cycle
//   in_data    WIDTH-bit sample (two's complement when SIGNED=1)
//   out_valid  frame result available
//   out_ready  consumer accepts the result
//   out_data   accumulator value, meaningful while out_valid=1
//   out_sat    at least one beat of the current frame saturated
module sat_accumulator #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 4,
  parameter int LEN       = 2,
  parameter bit SIGNED    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_sat
);

  // Elaboration-time parameter checks.
  if (ACC_WIDTH < WIDTH) begin : g_bad_acc_width
    $error("sat_accumulator: ACC_WIDTH must be >= WIDTH");
  end
  if (LEN < 1) begin : g_bad_len
    $error("sat_accumulator: LEN must be >= 1");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("sat_accumulator: WIDTH must be >= 2");
  end

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

  localparam logic [ACC_WIDTH-1:0] ACC_ZERO  = '0;
  localparam logic [ACC_WIDTH-1:0] ACC_ONES  = '1;
  // Signed extremes: 0111..1 and 1000..0.
  localparam logic [ACC_WIDTH-1:0] SMAX      = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMIN      = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(LEN - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     cnt;
  logic                 sat_q;

  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH:0]   sum_w;
  logic [ACC_WIDTH-1:0] sum_sat;
  logic                 clamp;
  logic                 beat;
  logic                 last_beat;
  logic                 take;

  // ---------------------------------------------------------------------
  // Sample extension to accumulator width. The replication is only legal
  // with a non-zero count, hence the generate split.
  // ---------------------------------------------------------------------
  if (ACC_WIDTH > WIDTH) begin : g_ext
    always_comb begin
      ext = {{(ACC_WIDTH-WIDTH){SIGNED & in_data[WIDTH-1]}}, in_data};
    end
  end else begin : g_no_ext
    always_comb begin
      ext = in_data;
    end
  end

  // ---------------------------------------------------------------------
  // Saturating add. Both operands are extended by one bit (sign or zero)
  // so the extra top bit tells overflow apart from a legal result.
  // Signed: overflow iff the two top bits differ; the top bit is then the
  // true sign of the sum, selecting the clamp direction. Mixed-sign adds
  // can never make the top bits differ.
  // Unsigned: the top bit is the carry out.
  // ---------------------------------------------------------------------
  always_comb begin
    sum_w   = {SIGNED & acc[ACC_WIDTH-1], acc} + {SIGNED & ext[ACC_WIDTH-1], ext};
    sum_sat = sum_w[ACC_WIDTH-1:0];
    clamp   = 1'b0;
    if (SIGNED) begin
      if (sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1]) begin
        clamp   = 1'b1;
        sum_sat = sum_w[ACC_WIDTH] ? SMIN : SMAX;
      end
    end else begin
      if (sum_w[ACC_WIDTH]) begin
        clamp   = 1'b1;
        sum_sat = ACC_ONES;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. in_ready is held low while rst_n is asserted so nothing
  // looks acceptable before reset is released.
  // ---------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_ACC: in_ready  = rst_n & ~clear;
      ST_OUT: out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  assign beat      = in_valid & in_ready;
  assign last_beat = (cnt == CNT_LAST);
  assign take      = out_valid & out_ready;

  // ---------------------------------------------------------------------
  // FSM: next state. clear wins over everything else.
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_ACC;
    end else begin
      case (state)
        ST_ACC: if (beat && last_beat) state_nxt = ST_OUT;
        ST_OUT: if (take)              state_nxt = ST_ACC;
        default:                       state_nxt = ST_ACC;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Datapath: accumulator, beat counter, sticky saturation flag.
  // In ST_OUT nothing but clear or the output handshake changes them, so
  // the result holds for any length of backpressure.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= ACC_ZERO;
      cnt   <= '0;
      sat_q <= 1'b0;
    end else if (clear) begin
      acc   <= ACC_ZERO;
      cnt   <= '0;
      sat_q <= 1'b0;
    end else if (beat) begin
      acc   <= sum_sat;
      sat_q <= sat_q | clamp;
      cnt   <= last_beat ? '0 : cnt + CNT_ONE;
    end else if (take) begin
      acc   <= ACC_ZERO;
      sat_q <= 1'b0;
    end
  end

  assign out_data = acc;
  assign out_sat  = sat_q;

endmodule

// File: tb/tb_sat_accumulator.sv
// Testbench for sat_accumulator. Three instances cover the parameter sets
// of interest:
//   u0: WIDTH=4 ACC_WIDTH=4 LEN=2 SIGNED=1 (defaults)
//   u1: WIDTH=4 ACC_WIDTH=4 LEN=3 SIGNED=1
//   u2: WIDTH=4 ACC_WIDTH=5 LEN=3 SIGNED=0
// Inputs change on the falling edge; outputs are sampled 1-2 time units
// after the falling edge. Expected results come from an integer model with
// explicit clamping and are queued as {id, sat, data}; the monitor pops
// one entry for every output handshake.
module tb_sat_accumulator;

  localparam int N = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT signals ----------------
  logic       clear     [N];
  logic       in_valid  [N];
  logic       in_ready  [N];
  logic [3:0] in_data   [N];
  logic       out_valid [N];
  logic       out_ready [N];
  logic       out_sat   [N];
  logic [4:0] out_data  [N];
  logic [3:0] od0, od1;
  logic [4:0] od2;

  assign out_data[0] = {1'b0, od0};
  assign out_data[1] = {1'b0, od1};
  assign out_data[2] = od2;

  sat_accumulator #(.WIDTH(4), .ACC_WIDTH(4), .LEN(2), .SIGNED(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .clear(clear[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(od0), .out_sat(out_sat[0])
  );

  sat_accumulator #(.WIDTH(4), .ACC_WIDTH(4), .LEN(3), .SIGNED(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(od1), .out_sat(out_sat[1])
  );

  sat_accumulator #(.WIDTH(4), .ACC_WIDTH(5), .LEN(3), .SIGNED(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .clear(clear[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(od2), .out_sat(out_sat[2])
  );

  // ---------------- configuration mirror ----------------
  int acc_w [N] = '{4, 4, 5};
  bit sgn   [N] = '{1'b1, 1'b1, 1'b0};
  int len   [N] = '{2, 3, 3};

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];   // {id[1:0], sat, data[4:0]}
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int ext_val(input int d, input logic [3:0] x);
    if (sgn[d] && x[3]) return int'(x) - 16;
    return int'(x);
  endfunction

  // Output monitor: one scoreboard entry per output handshake.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #2;
      for (int d = 0; d < N; d++) begin
        if (rst_n && out_valid[d] && out_ready[d]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 32'(out_valid[d]), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("out_id",   32'(d),           32'(e[7:6]));
            check("out_data", 32'(out_data[d]), 32'(e[4:0]));
            check("out_sat",  32'(out_sat[d]),  32'(e[5]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic send_beat(input int d, input logic [3:0] x);
    int n = 0;
    in_valid[d] = 1'b1;
    in_data[d]  = x;
    #1;
    while (!in_ready[d] && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      check("in_ready_timeout", 32'(in_ready[d]), 32'd1);
      @(negedge clk);
      in_valid[d] = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  // Drives one frame; when push=1 the model result is queued first.
  task automatic send_frame(input int d, input int b0, input int b1, input int b2,
                            input bit push);
    int b[3];
    int acc = 0;
    bit s = 1'b0;
    int hi, lo, mask;
    logic [7:0] e;
    b = '{b0, b1, b2};
    mask = (1 << acc_w[d]) - 1;
    if (sgn[d]) begin
      hi = (1 << (acc_w[d] - 1)) - 1;
      lo = -(1 << (acc_w[d] - 1));
    end else begin
      hi = mask;
      lo = 0;
    end
    for (int i = 0; i < len[d]; i++) begin
      acc = acc + ext_val(d, 4'(b[i]));
      if (acc > hi) begin acc = hi; s = 1'b1; end
      if (acc < lo) begin acc = lo; s = 1'b1; end
    end
    e = {2'(d), s, 5'(acc & mask)};
    if (push) exp_q.push_back(e);
    for (int i = 0; i < len[d]; i++) send_beat(d, 4'(b[i]));
    // Result must be visible one cycle after the last beat.
    check("latency_valid", 32'(out_valid[d]), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    for (int d = 0; d < N; d++) begin
      clear[d] = 1'b0; in_valid[d] = 1'b0; in_data[d] = 4'd0; out_ready[d] = 1'b1;
    end
    #1;
    for (int d = 0; d < N; d++) begin
      check("rst_out_valid", 32'(out_valid[d]), 32'd0);
      check("rst_out_data",  32'(out_data[d]),  32'd0);
      check("rst_out_sat",   32'(out_sat[d]),   32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < N; d++) check("rst_in_ready", 32'(in_ready[d]), 32'd1);
    @(negedge clk);

    // Directed signed frames, defaults.
    send_frame(0, 7, 3, 0, 1'b1);     // 7 (sat)
    send_frame(0, -8, -1, 0, 1'b1);   // -8 (sat)
    send_frame(0, 3, -2, 0, 1'b1);    // 1
    // Recovery after clamp, LEN=3.
    send_frame(1, 7, 7, -2, 1'b1);    // 5 (sat)
    // Unsigned, wider accumulator.
    send_frame(2, 15, 15, 15, 1'b1);  // 31 (sat)
    send_frame(2, 12, 9, 0, 1'b1);    // 21
    @(negedge clk);

    // Backpressure on u0 with in_valid held high.
    out_ready[0] = 1'b0;
    send_frame(0, 3, -2, 0, 1'b1);    // 1
    in_valid[0] = 1'b1;
    in_data[0]  = 4'd2;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid[0]), 32'd1);
      check("bp_out_data",  32'(out_data[0]),  32'd1);
      check("bp_out_sat",   32'(out_sat[0]),   32'd0);
      check("bp_in_ready",  32'(in_ready[0]),  32'd0);
    end
    exp_q.push_back({2'd0, 1'b0, 5'd6});  // next frame: 2 (held) + 4
    out_ready[0] = 1'b1;
    @(negedge clk);
    #1;
    check("bp_in_ready_after", 32'(in_ready[0]),  32'd1);
    check("bp_valid_after",    32'(out_valid[0]), 32'd0);
    @(negedge clk);                       // beat 2 taken on the edge before
    send_beat(0, 4'd4);
    check("bp_next_valid", 32'(out_valid[0]), 32'd1);
    @(negedge clk);

    // clear after one beat of 7; the beat offered during clear is dropped.
    send_beat(0, 4'd7);
    clear[0]    = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = 4'd7;
    #1;
    check("clr_in_ready", 32'(in_ready[0]), 32'd0);
    @(negedge clk);
    clear[0]    = 1'b0;
    in_valid[0] = 1'b0;
    #1;
    check("clr_out_valid", 32'(out_valid[0]), 32'd0);
    check("clr_acc",       32'(out_data[0]),  32'd0);
    @(negedge clk);
    send_frame(0, 2, 3, 0, 1'b1);     // 5
    @(negedge clk);

    // Asynchronous reset while a result is pending on u1.
    out_ready[1] = 1'b0;
    send_frame(1, 7, 7, 7, 1'b0);     // 7 (sat), discarded by reset
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid[1]), 32'd0);
    check("arst_out_data",  32'(out_data[1]),  32'd0);
    check("arst_out_sat",   32'(out_sat[1]),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready[1] = 1'b1;
    #1;
    check("arst_in_ready", 32'(in_ready[1]), 32'd1);
    @(negedge clk);
    send_frame(1, 1, 2, 3, 1'b1);     // 6, counter restarted from 0

    // Random frames across all instances.
    for (int k = 0; k < 30; k++) begin
      int d;
      d = int'($urandom_range(0, N - 1));
      send_frame(d, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Drain.
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sat_accumulator.md
Name: sat_accumulator

Overview:
- Parametrised saturating accumulator. Sums frames of LEN input samples with per-beat saturation, then presents one result.
- Supports signed (two's complement) or unsigned mode, a wider accumulator than the input, and a sticky per-frame saturation flag.
- Input and output use valid/ready handshakes. Sits between a sample source and a downstream consumer in arithmetic datapaths.

Parameters:
- WIDTH, 4, input sample width in bits (>=2).
- ACC_WIDTH, 4, accumulator/output width in bits (>=WIDTH).
- LEN, 2, samples per frame (>=1).
- SIGNED, 1, 1 = two's-complement saturation; 0 = unsigned saturation.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous frame abort, highest priority after reset
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts a sample this cycle
- in_data  input  WIDTH  sample
- out_valid  output  1  frame result available
- out_ready  input  1  consumer accepts result
- out_data  output  ACC_WIDTH  accumulator value
- out_sat  output  1  saturation occurred at least once in current frame

Behaviour:
- Reset (rst_n=0, async):
  - state=ACC; acc=0, cnt=0, out_sat=0, out_valid=0; in_ready becomes 1 once rst_n=1.
- States:
  - ACC: in_ready = ~clear; out_valid=0.
  - OUT: in_ready=0; out_valid=1.
- Input beat:
  - Accepted when in_valid & in_ready.
  - Sample is sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_WIDTH.
  - Added to acc with saturation: acc <= sat(acc + ext). The sum is computed one bit wider before clamping.
- Saturation, SIGNED=1:
  - Both operands non-negative and result sign bit set -> acc = 2^(ACC_WIDTH-1)-1 (e.g. 4'b0111).
  - Both operands negative and result sign bit clear -> acc = -2^(ACC_WIDTH-1) (4'b1000).
  - Mixed signs never saturate.
- Saturation, SIGNED=0:
  - Carry out -> acc = all ones. Underflow is impossible.
- Clamping is not sticky on the value: later beats add to the clamped value. out_sat is sticky; it is set on any clamping beat and cleared only at frame end, clear, or reset.
- Frame counting:
  - cnt increments per accepted beat.
  - On the LEN-th accepted beat: acc updated, cnt=0, state -> OUT. out_valid rises the next cycle (1-cycle latency from last beat).
- OUT:
  - out_data and out_sat hold stable while out_valid & ~out_ready, for any backpressure length.
  - On out_valid & out_ready: acc=0, out_sat=0, state -> ACC. in_ready is 1 the following cycle.
  - Minimum frame period: LEN+1 cycles.
- clear=1 (any state):
  - Next cycle: acc=0, cnt=0, out_sat=0, state=ACC, out_valid=0. A pending result is discarded.
  - in_ready=0 while clear=1, so no beat is accepted in the same cycle.
- out_data:
  - Equals acc at all times; meaningful only while out_valid=1.
- Reset mid-frame or mid-OUT: immediate return to reset values; the partial frame is lost.
- Assertions (elaboration): ACC_WIDTH>=WIDTH, LEN>=1.

Test Plan:
- Defaults (W=4, ACC=4, LEN=2, SIGNED=1):
  - Beats 7, 3 -> one cycle after 2nd beat: out_valid=1, out_data=4'b0111, out_sat=1.
  - Beats -8, -1 -> out_data=4'b1000, out_sat=1.
  - Beats 3, -2 -> out_data=1, out_sat=0.
- Recovery after clamp (LEN=3, defaults otherwise): beats 7, 7, -2 -> out_data=5, out_sat=1.
- Backpressure: hold out_ready=0 for 5 cycles after result 1 with in_valid=1 throughout -> out_valid/out_data/out_sat stable, in_ready=0. Raise out_ready -> handshake, in_ready=1 next cycle, next frame starts from 0.
- Unsigned with wider accumulator (W=4, ACC=5, LEN=3, SIGNED=0): beats 15, 15, 15 -> 30 then clamp, out_data=31, out_sat=1. Beats 12, 9, 0 -> out_data=21, out_sat=0.
- clear / reset:
  - After one beat of 7 (out_sat would be 0), pulse clear with in_valid=1 -> beat not accepted, acc=0, cnt=0. Next beats 2, 3 -> out_data=5.
  - Drop rst_n asynchronously while out_valid=1 -> out_valid=0 immediately, all state zero.
